// File: rtl/mips_ctrl_pkg.sv
// Shared control-interface definitions for the multicycle MIPS: opcodes, funct codes, ALU codes,
// mux selects, fault codes and the controller state encoding.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_FETCH   = 4'd0,
    ST_DECODE  = 4'd1,
    ST_MEMADR  = 4'd2,
    ST_MEMRD   = 4'd3,
    ST_MEMWB   = 4'd4,
    ST_MEMWR   = 4'd5,
    ST_EXECUTE = 4'd6,
    ST_ALUWB   = 4'd7,
    ST_ADDIEXE = 4'd8,
    ST_ADDIWB  = 4'd9,
    ST_BEQCMP  = 4'd10,
    ST_BEQCHK  = 4'd11,
    ST_JUMP    = 4'd12,
    ST_FAULT   = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_SRL = 6'b000010;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_SLL = 4'b0010;
  localparam logic [3:0] ALU_SRL = 4'b0011;
  localparam logic [3:0] ALU_AND = 4'b0100;
  localparam logic [3:0] ALU_OR  = 4'b0101;

  localparam logic [1:0] SRCA_PC = 2'b00;
  localparam logic [1:0] SRCA_A  = 2'b01;
  localparam logic [1:0] SRCA_B  = 2'b10;

  localparam logic [2:0] SRCB_B       = 3'b000;
  localparam logic [2:0] SRCB_FOUR    = 3'b001;
  localparam logic [2:0] SRCB_IMM     = 3'b010;
  localparam logic [2:0] SRCB_IMM_SH2 = 3'b011;
  localparam logic [2:0] SRCB_SHAMT   = 3'b100;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] FC_NONE    = 2'b00;
  localparam logic [1:0] FC_OP      = 2'b01;
  localparam logic [1:0] FC_FUNCT   = 2'b10;
  localparam logic [1:0] FC_TIMEOUT = 2'b11;

  typedef struct packed {
    logic       memread;
    logic       memwrite;
    logic       iord;
    logic       irwrite;
    logic       mdrwrite;
    logic       regwrite;
    logic       regdst;
    logic       memtoreg;
    logic [1:0] alusrca;
    logic [2:0] alusrcb;
    logic [3:0] alucontrol;
    logic       aluoutwrite;
    logic       pcen;
    logic [1:0] pcsrc;
    logic       fault;
    logic [1:0] fault_code;
  } ctrl_t;

endpackage

// File: rtl/mips_funct_dec.sv
// R-type funct decoder: ALU operation, shift-operand flag and legality of the funct field.
module mips_funct_dec
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] funct,
  output logic [3:0] alucontrol,
  output logic       shift,
  output logic       legal
);

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    alucontrol = ALU_ADD;
    shift      = 1'b0;
    legal      = 1'b1;
    case (funct)
      FN_ADD:  alucontrol = ALU_ADD;
      FN_SUB:  alucontrol = ALU_SUB;
      FN_AND:  alucontrol = ALU_AND;
      FN_OR:   alucontrol = ALU_OR;
      FN_SLL: begin alucontrol = ALU_SLL; shift = 1'b1; end
      FN_SRL: begin alucontrol = ALU_SRL; shift = 1'b1; end
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/mips_mc_controller.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute, drives ALU control and datapath
// enables, and faults on illegal encodings or a memory that never answers.
module mips_mc_controller
  import mips_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       memread,
  output logic       memwrite,
  output logic       iord,
  output logic       irwrite,
  output logic       mdrwrite,
  output logic       regwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic [1:0] alusrca,
  output logic [2:0] alusrcb,
  output logic [3:0] alucontrol,
  output logic       aluoutwrite,
  output logic       pcen,
  output logic [1:0] pcsrc,
  output logic       fault,
  output logic [1:0] fault_code,
  output logic [3:0] state_dbg
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t        state_q, state_d;
  logic [1:0]    fcode_q, fcode_d;
  logic [CW-1:0] wait_cnt;
  logic          mem_state, timeout;
  logic [3:0]    fn_alu;
  logic          fn_shift, fn_legal;
  ctrl_t         ctrl, ctrl_g;

  mips_funct_dec u_funct_dec (
    .funct      (funct),
    .alucontrol (fn_alu),
    .shift      (fn_shift),
    .legal      (fn_legal)
  );

  assign mem_state = (state_q == ST_FETCH) || (state_q == ST_MEMRD) || (state_q == ST_MEMWR);
  assign timeout   = (TIMEOUT != 0) && mem_state && !mem_ready && (wait_cnt == CW'(TIMEOUT - 1));

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_FETCH;
      fcode_q  <= FC_NONE;
      wait_cnt <= '0;
    end else begin
      state_q <= state_d;
      fcode_q <= fcode_d;
      if (state_d != state_q)          wait_cnt <= '0;
      else if (mem_state && !mem_ready) wait_cnt <= wait_cnt + CW'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    fcode_d = fcode_q;
    ctrl    = '0;
    case (state_q)
      ST_FETCH: begin
        ctrl.memread = 1'b1;
        ctrl.alusrcb = SRCB_FOUR;
        ctrl.irwrite = mem_ready;
        ctrl.pcen    = mem_ready;
        if (mem_ready)    state_d = ST_DECODE;
        else if (timeout) begin state_d = ST_FAULT; fcode_d = FC_TIMEOUT; end
      end
      ST_DECODE: begin
        // Branch target is computed here so BEQCHK can load it from ALUOut.
        ctrl.alusrcb     = SRCB_IMM_SH2;
        ctrl.aluoutwrite = 1'b1;
        case (op)
          OP_LW, OP_SW: state_d = ST_MEMADR;
          OP_RTYPE: begin
            if (fn_legal) state_d = ST_EXECUTE;
            else begin state_d = ST_FAULT; fcode_d = FC_FUNCT; end
          end
          OP_ADDI: state_d = ST_ADDIEXE;
          OP_BEQ:  state_d = ST_BEQCMP;
          OP_J:    state_d = ST_JUMP;
          default: begin state_d = ST_FAULT; fcode_d = FC_OP; end
        endcase
      end
      ST_MEMADR: begin
        ctrl.alusrca     = SRCA_A;
        ctrl.alusrcb     = SRCB_IMM;
        ctrl.aluoutwrite = 1'b1;
        state_d          = (op == OP_LW) ? ST_MEMRD : ST_MEMWR;
      end
      ST_MEMRD: begin
        ctrl.memread  = 1'b1;
        ctrl.iord     = 1'b1;
        ctrl.mdrwrite = mem_ready;
        if (mem_ready)    state_d = ST_MEMWB;
        else if (timeout) begin state_d = ST_FAULT; fcode_d = FC_TIMEOUT; end
      end
      ST_MEMWB: begin
        ctrl.regwrite = 1'b1;
        ctrl.memtoreg = 1'b1;
        state_d       = ST_FETCH;
      end
      ST_MEMWR: begin
        ctrl.memwrite = 1'b1;
        ctrl.iord     = 1'b1;
        if (mem_ready)    state_d = ST_FETCH;
        else if (timeout) begin state_d = ST_FAULT; fcode_d = FC_TIMEOUT; end
      end
      ST_EXECUTE: begin
        ctrl.aluoutwrite = 1'b1;
        ctrl.alucontrol  = fn_alu;
        ctrl.alusrca     = fn_shift ? SRCA_B : SRCA_A;
        ctrl.alusrcb     = fn_shift ? SRCB_SHAMT : SRCB_B;
        state_d          = ST_ALUWB;
      end
      ST_ALUWB: begin
        ctrl.regwrite = 1'b1;
        ctrl.regdst   = 1'b1;
        state_d       = ST_FETCH;
      end
      ST_ADDIEXE: begin
        ctrl.alusrca     = SRCA_A;
        ctrl.alusrcb     = SRCB_IMM;
        ctrl.aluoutwrite = 1'b1;
        state_d          = ST_ADDIWB;
      end
      ST_ADDIWB: begin
        ctrl.regwrite = 1'b1;
        state_d       = ST_FETCH;
      end
      ST_BEQCMP: begin
        ctrl.alusrca    = SRCA_A;
        ctrl.alusrcb    = SRCB_B;
        ctrl.alucontrol = ALU_SUB;
        state_d         = ST_BEQCHK;
      end
      ST_BEQCHK: begin
        ctrl.pcsrc = PCSRC_ALUOUT;
        ctrl.pcen  = zero;
        state_d    = ST_FETCH;
      end
      ST_JUMP: begin
        ctrl.pcsrc = PCSRC_JUMP;
        ctrl.pcen  = 1'b1;
        state_d    = ST_FETCH;
      end
      ST_FAULT: begin
        ctrl.fault      = 1'b1;
        ctrl.fault_code = fcode_q;
      end
      default: begin
        state_d = ST_FAULT;
        fcode_d = FC_OP;
      end
    endcase
  end

  // Outputs drop to zero the moment reset asserts, without waiting for a clock edge.
  assign ctrl_g    = reset_n ? ctrl : '0;
  assign state_dbg = reset_n ? state_q : 4'd0;

  assign memread     = ctrl_g.memread;
  assign memwrite    = ctrl_g.memwrite;
  assign iord        = ctrl_g.iord;
  assign irwrite     = ctrl_g.irwrite;
  assign mdrwrite    = ctrl_g.mdrwrite;
  assign regwrite    = ctrl_g.regwrite;
  assign regdst      = ctrl_g.regdst;
  assign memtoreg    = ctrl_g.memtoreg;
  assign alusrca     = ctrl_g.alusrca;
  assign alusrcb     = ctrl_g.alusrcb;
  assign alucontrol  = ctrl_g.alucontrol;
  assign aluoutwrite = ctrl_g.aluoutwrite;
  assign pcen        = ctrl_g.pcen;
  assign pcsrc       = ctrl_g.pcsrc;
  assign fault       = ctrl_g.fault;
  assign fault_code  = ctrl_g.fault_code;

endmodule

// File: tb/tb_mips_mc_controller.sv
// Self-checking bench for mips_mc_controller: random instruction streams with random memory
// latency against an instruction-level reference model, plus timeout, fault and reset scenarios.
module tb_mips_mc_controller;
  import mips_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [5:0] op = '0, funct = '0;
  logic       zero = 1'b0, mem_ready = 1'b0;
  logic       memread, memwrite, iord, irwrite, mdrwrite, regwrite, regdst, memtoreg;
  logic [1:0] alusrca, pcsrc, fault_code;
  logic [2:0] alusrcb;
  logic [3:0] alucontrol, state_dbg;
  logic       aluoutwrite, pcen, fault;
  logic [27:0] act;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  mips_mc_controller #(.TIMEOUT(16)) dut (
    .clk(clk), .reset_n(reset_n), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .memread(memread), .memwrite(memwrite), .iord(iord), .irwrite(irwrite),
    .mdrwrite(mdrwrite), .regwrite(regwrite), .regdst(regdst), .memtoreg(memtoreg),
    .alusrca(alusrca), .alusrcb(alusrcb), .alucontrol(alucontrol),
    .aluoutwrite(aluoutwrite), .pcen(pcen), .pcsrc(pcsrc), .fault(fault),
    .fault_code(fault_code), .state_dbg(state_dbg)
  );

  assign act = {memread, memwrite, iord, irwrite, mdrwrite, regwrite, regdst, memtoreg,
                alusrca, alusrcb, alucontrol, aluoutwrite, pcen, pcsrc, fault, fault_code,
                state_dbg};

  // Reference: what each instruction phase must present on the control bus.
  function automatic logic [27:0] exp_ctrl(state_t st, logic [5:0] o, logic [5:0] fn,
                                           logic rdy, logic z, logic [1:0] fc);
    logic mr = 0, mw = 0, ad = 0, irw = 0, mdw = 0, rw = 0, rd = 0, m2r = 0;
    logic aow = 0, pe = 0, flt = 0;
    logic [1:0] sa = 0, ps = 0, fcd = 0;
    logic [2:0] sb = 0;
    logic [3:0] ac = 0;
    case (st)
      ST_FETCH:   begin mr = 1; sb = 3'b001; irw = rdy; pe = rdy; end
      ST_DECODE:  begin sb = 3'b011; aow = 1; end
      ST_MEMADR:  begin sa = 2'b01; sb = 3'b010; aow = 1; end
      ST_MEMRD:   begin mr = 1; ad = 1; mdw = rdy; end
      ST_MEMWB:   begin rw = 1; m2r = 1; end
      ST_MEMWR:   begin mw = 1; ad = 1; end
      ST_EXECUTE: begin
        aow = 1;
        case (fn)
          6'b100000: begin sa = 2'b01; ac = 4'b0000; end
          6'b100010: begin sa = 2'b01; ac = 4'b0001; end
          6'b100100: begin sa = 2'b01; ac = 4'b0100; end
          6'b100101: begin sa = 2'b01; ac = 4'b0101; end
          6'b000000: begin sa = 2'b10; sb = 3'b100; ac = 4'b0010; end
          default:   begin sa = 2'b10; sb = 3'b100; ac = 4'b0011; end
        endcase
      end
      ST_ALUWB:   begin rw = 1; rd = 1; end
      ST_ADDIEXE: begin sa = 2'b01; sb = 3'b010; aow = 1; end
      ST_ADDIWB:  begin rw = 1; end
      ST_BEQCMP:  begin sa = 2'b01; ac = 4'b0001; end
      ST_BEQCHK:  begin ps = 2'b01; pe = z; end
      ST_JUMP:    begin ps = 2'b10; pe = 1; end
      default:    begin flt = 1; fcd = fc; end
    endcase
    return {mr, mw, ad, irw, mdw, rw, rd, m2r, sa, sb, ac, aow, pe, ps, flt, fcd, st};
  endfunction

  // One cycle: drive inputs on the falling edge, compare shortly after.
  task automatic step(input string name, input state_t st, input logic rdy, input logic z,
                      input logic [1:0] fc);
    logic [27:0] e;
    @(negedge clk);
    mem_ready = rdy;
    zero      = z;
    #1;
    e = exp_ctrl(st, op, funct, rdy, z, fc);
    vectors++;
    if (act !== e) begin
      errors++;
      $display("FAIL %s op=%b funct=%b: got %h expected %h", name, op, funct, act, e);
    end
  endtask

  // Memory phase with a random number of not-ready cycles before completion.
  task automatic mem_phase(input string name, input state_t st);
    int waits = $urandom_range(0, 3);
    for (int i = 0; i < waits; i++) step(name, st, 1'b0, 1'($urandom), FC_NONE);
    step(name, st, 1'b1, 1'($urandom), FC_NONE);
  endtask

  task automatic any_step(input string name, input state_t st);
    step(name, st, 1'($urandom), 1'($urandom), FC_NONE);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n   = 1'b0;
    mem_ready = 1'($urandom);
    #1;
    vectors++;
    if (act !== 28'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected %h", act, 28'h0);
    end
    @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    op = OP_LW;
    step("reset_fetch", ST_FETCH, 1'b0, 1'b0, FC_NONE);
  endtask

  task automatic test_random_instr();
    logic [5:0] rfn [6] = '{FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLL, FN_SRL};
    do_reset();
    for (int n = 0; n < 60; n++) begin
      int kind = $urandom_range(0, 5);
      funct = 6'($urandom);
      case (kind)
        0: op = OP_LW;
        1: op = OP_SW;
        2: begin op = OP_RTYPE; funct = rfn[$urandom_range(0, 5)]; end
        3: op = OP_ADDI;
        4: op = OP_BEQ;
        default: op = OP_J;
      endcase
      mem_phase("fetch", ST_FETCH);
      any_step("decode", ST_DECODE);
      case (kind)
        0: begin any_step("memadr", ST_MEMADR); mem_phase("memrd", ST_MEMRD);
                 any_step("memwb", ST_MEMWB); end
        1: begin any_step("memadr", ST_MEMADR); mem_phase("memwr", ST_MEMWR); end
        2: begin any_step("execute", ST_EXECUTE); any_step("aluwb", ST_ALUWB); end
        3: begin any_step("addiexe", ST_ADDIEXE); any_step("addiwb", ST_ADDIWB); end
        4: begin any_step("beqcmp", ST_BEQCMP); any_step("beqchk", ST_BEQCHK); end
        default: any_step("jump", ST_JUMP);
      endcase
    end
  endtask

  task automatic test_timeout();
    do_reset();
    op = OP_J;
    // 15 stalled cycles then ready on the last allowed cycle: ready wins.
    for (int i = 0; i < 15; i++) step("fetch_stall", ST_FETCH, 1'b0, 1'b0, FC_NONE);
    step("fetch_ready_at_limit", ST_FETCH, 1'b1, 1'b0, FC_NONE);
    step("decode_after_limit", ST_DECODE, 1'b0, 1'b0, FC_NONE);
    step("jump_after_limit", ST_JUMP, 1'b0, 1'b0, FC_NONE);
    for (int i = 0; i < 16; i++) step("fetch_timeout_wait", ST_FETCH, 1'b0, 1'b0, FC_NONE);
    for (int i = 0; i < 4; i++) step("fault_timeout", ST_FAULT, 1'(i), 1'b0, FC_TIMEOUT);
  endtask

  task automatic test_illegal();
    do_reset();
    op = 6'b111111;
    step("fetch_illop", ST_FETCH, 1'b1, 1'b0, FC_NONE);
    step("decode_illop", ST_DECODE, 1'b0, 1'b0, FC_NONE);
    for (int i = 0; i < 6; i++) step("fault_op", ST_FAULT, 1'(i), 1'(i >> 1), FC_OP);
    do_reset();
    op = OP_RTYPE; funct = 6'b101010;
    step("fetch_illfn", ST_FETCH, 1'b1, 1'b0, FC_NONE);
    step("decode_illfn", ST_DECODE, 1'b1, 1'b0, FC_NONE);
    for (int i = 0; i < 3; i++) step("fault_funct", ST_FAULT, 1'(i), 1'b0, FC_FUNCT);
  endtask

  task automatic test_reset_mid_memrd();
    do_reset();
    op = OP_LW;
    step("mid_fetch", ST_FETCH, 1'b1, 1'b0, FC_NONE);
    step("mid_decode", ST_DECODE, 1'b0, 1'b0, FC_NONE);
    step("mid_memadr", ST_MEMADR, 1'b0, 1'b0, FC_NONE);
    step("mid_memrd", ST_MEMRD, 1'b1, 1'b0, FC_NONE);
    #1 reset_n = 1'b0;
    #1;
    vectors++;
    if (act !== 28'h0) begin
      errors++;
      $display("FAIL reset_mid_memrd: got %h expected %h", act, 28'h0);
    end
    @(posedge clk);
    #1 reset_n = 1'b1;
    step("restart_fetch", ST_FETCH, 1'b0, 1'b0, FC_NONE);
  endtask

  initial begin
    test_reset();
    test_random_instr();
    test_timeout();
    test_illegal();
    test_reset_mid_memrd();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not complete in time");
    $fatal(1);
  end

endmodule
